mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive D grants taken while I is waiting, after which I is granted.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 i_read  in  1  instruction-fetch read request; I side is read-only.
REQ-005 i_addr  in  32  I request address.
REQ-006 i_rdata  out  32  I read data; valid while i_ready is high.
REQ-007 i_ready  out  1  one-cycle pulse that completes an I transaction.
REQ-008 d_read  in  1  data-cache read request.
REQ-009 d_write  in  1  data-cache write request.
REQ-010 d_byte  in  1  D byte select; passed to mem_byte.
REQ-011 d_addr  in  32  D request address.
REQ-012 d_wdata  in  32  D write data.
REQ-013 d_rdata  out  32  D read data; valid while d_ready is high.
REQ-014 d_ready  out  1  one-cycle pulse that completes a D transaction.
REQ-015 mem_oe  out  1  main-memory read strobe.
REQ-016 mem_we  out  1  main-memory write strobe.
REQ-017 mem_byte  out  1  main-memory byte select.
REQ-018 mem_addr  out  32  main-memory address.
REQ-019 mem_wdata  out  32  main-memory write data.
REQ-020 mem_rdata  in  32  main-memory read data.
REQ-021 mem_ready  in  1  main memory signals that the access is done.
REQ-022 busy  out  1  high in MEM and RESP states.

Function
REQ-023 FSM states: IDLE, MEM, RESP.
- IDLE->MEM when any request is sampled.
- MEM->RESP on mem_ready=1.
- RESP->IDLE unconditionally.
REQ-024 Requests are defined as:
- I request = i_read.
- D request = d_read|d_write.
- d_read=d_write=1 is treated as a write.
REQ-025 Arbitration in IDLE:
- Only one requester active: that requester wins.
- Both active: D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
REQ-026 starve_cnt behaviour:
- Increments, saturating at STARVE_LIMIT, on a D grant with i_read=1.
- Clears to 0 on any I grant.
REQ-027 At grant, the arbiter registers: owner, address, write data, byte select, op (read/write).
- An I grant always sets op=read and mem_byte=0.
REQ-028 In MEM, the strobes are driven from the registered values:
- mem_oe = op read; mem_we = op write.
- mem_addr, mem_wdata and mem_byte come from the registered values.
REQ-029 The strobes are held until the cycle in which mem_ready is sampled high.
REQ-030 Read data: on mem_ready in MEM, mem_rdata is captured into the owner's rdata register.
- The non-owner's rdata is unchanged.
- A write leaves both rdata registers unchanged.
REQ-031 In RESP:
- mem_oe=mem_we=0.
- Exactly the owner's ready=1 for one cycle.
REQ-032 Latency: a request sampled in IDLE at cycle 0 gives strobes at cycle 1.
- If mem_ready arrives at cycle k, ready is asserted at cycle k+1.
- Minimum is 3 cycles, request to IDLE.
REQ-033 A requester shall deassert its request on the edge where it samples ready=1.
- A request still high in the following IDLE cycle starts a new transaction.
REQ-034 A request dropped during MEM does not abort the transaction; ready still pulses.
REQ-035 Request inputs changing during MEM/RESP do not affect mem_addr, mem_wdata or mem_byte.
REQ-036 mem_ready sampled in IDLE or RESP is ignored.
REQ-037 mem_addr, mem_wdata and mem_byte hold their last values outside MEM; only the strobes qualify them.

Reset
REQ-038 While reset=0, asynchronously:
- state=IDLE, starve_cnt=0.
- mem_oe=mem_we=mem_byte=0.
- i_ready=d_ready=busy=0.
- mem_addr=mem_wdata=i_rdata=d_rdata=0.
REQ-039 Reset asserted in MEM or RESP aborts the transaction; no ready pulse follows after reset is released.
REQ-040 The first request is evaluated on the first rising edge after reset returns to 1.

Verification
REQ-041 Single I read: i_read=1, i_addr=0x100, mem_ready at 2nd MEM cycle with mem_rdata=0xDEADBEEF -> mem_oe high 2 cycles, mem_addr=0x100, then i_ready=1 for one cycle with i_rdata=0xDEADBEEF.
REQ-042 D byte write: d_write=1, d_byte=1, d_addr=0x40, d_wdata=0xAB -> mem_we=1, mem_byte=1, mem_wdata=0xAB until mem_ready, then d_ready pulse; d_rdata unchanged.
REQ-043 Simultaneous requests: i_read and d_read are both held, and every D re-requests immediately -> D is granted 4 times, then I on the 5th; starve_cnt returns to 0.
REQ-044 Request dropped mid-transaction: d_read dropped in MEM -> the access completes and d_ready still pulses; next state is IDLE with no new grant.
REQ-045 Reset in MEM: reset=0 while mem_oe=1 -> mem_oe=0 immediately, all outputs reset; no ready after release; a fresh i_read proceeds normally.
REQ-046 Stray mem_ready: mem_ready=1 in IDLE with no request -> no state change and no ready pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: an instruction-fetch read port (I) and a data
// port (D) share one memory. D has priority, but I cannot be starved forever.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          owner_d_q, owner_d_d;   // 1: D owns the transaction, 0: I
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic i_req, d_req, grant_i;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_i = i_req & (~d_req | (starve_q == LIMIT));

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so
    // no path through the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    starve_d  = starve_q;
    owner_d_d = owner_d_q;
    we_d      = we_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d = S_MEM;
          if (grant_i) begin
            owner_d_d = 1'b0;
            we_d      = 1'b0;
            byte_d    = 1'b0;
            addr_d    = i_addr;
            starve_d  = '0;
          end else begin
            owner_d_d = 1'b1;
            we_d      = d_write;
            byte_d    = d_byte;
            addr_d    = d_addr;
            wdata_d   = d_wdata;
            if (i_req && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
          end
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_d_q) d_rdata_d = mem_rdata;
            else           i_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      owner_d_q <= owner_d_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Address/data buses hold their last values; only the strobes qualify them.
  assign mem_oe    = (state_q == S_MEM) & ~we_q;
  assign mem_we    = (state_q == S_MEM) &  we_q;
  assign mem_byte  = byte_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = (state_q == S_RESP) & ~owner_d_q;
  assign d_ready   = (state_q == S_RESP) &  owner_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions with a
// response scoreboard, plus hand-written sequences for the corner cases.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write, d_byte;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready;
  logic        mem_oe, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  typedef struct {
    bit          i_rd, d_rd, d_wr, d_byt;
    logic [31:0] i_adr, d_adr, d_wd, rdata;
    int          wait_n;   // MEM cycles before mem_ready is raised
    bit          hold;     // keep requests high after ready
    bit          exp_d, exp_we, exp_byte;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } resp_t;

  vec_t        vecs[$];
  resp_t       sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  function automatic vec_t mk(input bit i_rd, input bit d_rd, input bit d_wr,
                              input bit d_byt, input logic [31:0] i_adr,
                              input logic [31:0] d_adr, input logic [31:0] d_wd,
                              input logic [31:0] rdata, input int wait_n,
                              input bit hold, input bit exp_d, input bit exp_we,
                              input bit exp_byte, input logic [31:0] exp_addr);
    vec_t v;
    v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr; v.d_byt = d_byt;
    v.i_adr = i_adr; v.d_adr = d_adr; v.d_wd = d_wd; v.rdata = rdata;
    v.wait_n = wait_n; v.hold = hold;
    v.exp_d = exp_d; v.exp_we = exp_we; v.exp_byte = exp_byte; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Advance one clock; sample 1 time unit after the edge and score any ready.
  task automatic step();
    resp_t r;
    @(posedge clk);
    #1;
    if (i_ready || d_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {30'b0, d_ready, i_ready}, 32'd0);
      end else begin
        r = sb.pop_front();
        check("ready_owner", {30'b0, d_ready, i_ready}, r.is_d ? 32'd2 : 32'd1);
        check("owner_rdata", r.is_d ? d_rdata : i_rdata, r.rdata);
        check("other_rdata", r.is_d ? i_rdata : d_rdata, r.is_d ? m_i_rdata : m_d_rdata);
      end
    end
  endtask

  task automatic drop_reqs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_byte = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_oe"},        mem_oe,    0);
    check({tag, "_we"},        mem_we,    0);
    check({tag, "_byte"},      mem_byte,  0);
    check({tag, "_addr"},      mem_addr,  0);
    check({tag, "_wdata"},     mem_wdata, 0);
    check({tag, "_i_rdata"},   i_rdata,   0);
    check({tag, "_d_rdata"},   d_rdata,   0);
    check({tag, "_i_ready"},   i_ready,   0);
    check({tag, "_d_ready"},   d_ready,   0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    resp_t r;
    string t;
    t = $sformatf("v%0d", idx);
    i_read = v.i_rd; d_read = v.d_rd; d_write = v.d_wr; d_byte = v.d_byt;
    i_addr = v.i_adr; d_addr = v.d_adr; d_wdata = v.d_wd;
    r.is_d = v.exp_d;
    if (v.exp_we) begin
      r.rdata = v.exp_d ? m_d_rdata : m_i_rdata;
    end else begin
      r.rdata = v.rdata;
      if (v.exp_d) m_d_rdata = v.rdata;
      else         m_i_rdata = v.rdata;
    end
    sb.push_back(r);
    step();
    check({t, "_busy_mem"}, busy, 1);
    for (int c = 0; c <= v.wait_n; c++) begin
      if (c == v.wait_n) begin
        mem_ready = 1'b1; mem_rdata = v.rdata;
      end else begin
        mem_rdata = ~v.rdata;
      end
      check({t, "_oe"},   mem_oe,   {31'b0, ~v.exp_we});
      check({t, "_we"},   mem_we,   {31'b0,  v.exp_we});
      check({t, "_addr"}, mem_addr, v.exp_addr);
      check({t, "_byte"}, mem_byte, {31'b0, v.exp_byte});
      if (v.exp_we) check({t, "_wdata"}, mem_wdata, v.d_wd);
      step();
    end
    mem_ready = 1'b0;
    check({t, "_resp_oe"},   {mem_oe, mem_we}, 0);
    check({t, "_resp_busy"}, busy, 1);
    check({t, "_i_ready"},   i_ready, {31'b0, ~v.exp_d});
    check({t, "_d_ready"},   d_ready, {31'b0,  v.exp_d});
    if (!v.hold) drop_reqs();
    step();
    check({t, "_idle_busy"},  busy, 0);
    check({t, "_idle_ready"}, {i_ready, d_ready}, 0);
  endtask

  initial begin
    resp_t r;
    reset = 1'b0;
    drop_reqs();
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    //        i  dr dw db i_addr     d_addr     d_wdata    rdata       w  hold eD eW eB exp_addr
    vecs.push_back(mk(1, 0, 0, 0, 32'h100, 32'h0,   32'h0,    32'hDEADBEEF, 1, 0, 0, 0, 0, 32'h100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0,   32'h40,  32'hAB,   32'h11111111, 2, 0, 1, 1, 1, 32'h40));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h80,  32'h0,    32'h12345678, 0, 0, 1, 0, 0, 32'h80));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   32'hC0,  32'h55AA, 32'h22222222, 0, 0, 1, 1, 0, 32'hC0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h204, 32'h0,   32'h0,    32'hCAFEF00D, 3, 0, 0, 0, 0, 32'h204));
    for (int k = 0; k < STARVE_LIMIT; k++)
      vecs.push_back(mk(1, 1, 0, 1, 32'h300, 32'h400, 32'h0, 32'h1000 + k, 0, 1, 1, 0, 1, 32'h400));
    vecs.push_back(mk(1, 1, 0, 1, 32'h300, 32'h400, 32'h0,    32'h2000,     0, 1, 0, 0, 0, 32'h300));
    vecs.push_back(mk(1, 1, 0, 1, 32'h300, 32'h400, 32'h0,    32'h3000,     1, 0, 1, 0, 1, 32'h400));

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    step();
    check("post_rst_busy", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Request dropped mid-transaction: access still completes and ready pulses.
    d_read = 1'b1; d_addr = 32'h500;
    r.is_d = 1'b1; r.rdata = 32'h0BADF00D; m_d_rdata = 32'h0BADF00D;
    sb.push_back(r);
    step();
    d_read = 1'b0;
    check("drop_oe", mem_oe, 1);
    step();
    check("drop_oe_held", mem_oe, 1);
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ready = 1'b0;
    check("drop_d_ready", d_ready, 1);
    step();
    check("drop_idle", busy, 0);
    step();
    check("drop_no_regrant", {busy, mem_oe}, 0);

    // Stray mem_ready in IDLE with no request.
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    step();
    check("stray_busy", busy, 0);
    check("stray_ready", {i_ready, d_ready}, 0);
    check("stray_d_rdata", d_rdata, m_d_rdata);
    mem_ready = 1'b0;

    // Reset while in MEM aborts the transaction.
    i_read = 1'b1; i_addr = 32'h600;
    step();
    check("rmem_oe", mem_oe, 1);
    reset = 1'b0;
    #1;
    m_i_rdata = '0; m_d_rdata = '0;
    check_reset_outputs("rmem");
    step();
    check("rmem_held", busy, 0);
    i_read = 1'b0;
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    check("rmem_after_busy", busy, 0);
    check("rmem_after_ready", {i_ready, d_ready}, 0);
    run_vec(mk(1, 0, 0, 0, 32'h700, 32'h0, 32'h0, 32'h77777777, 0, 0, 0, 0, 0, 32'h700), 99);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
